fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences the asynchronous-read program memory ROM. It drives the byte address to the ROM, captures the returned instruction into an IF/ID holding register with a valid/stall handshake toward decode, and applies branch/jump redirects with a one-bubble flush. It sits between the ROM and the decode stage of the MIPS pipeline, and reports halts and fetch faults to the top level.

---
 rtl/fetch_sequencer_pkg.sv | 14 +
 rtl/fetch_sequencer_if_id_register.sv | 35 +++
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state encoding and word geometry for the fetch sequencer
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

endpackage

// File: rtl/fetch_sequencer_if_id_register.sv
// rtl/fetch_sequencer_if_id_register.sv - IF/ID holding register with enable and valid-only flush
module fetch_sequencer_if_id_register #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] d_instruction,
  input  logic [DATA_WIDTH-1:0] d_pc,
  input  logic [DATA_WIDTH-1:0] d_pc_plus4,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4
);

  // Flush drops only the valid bit so the last instruction stays observable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid       <= 1'b0;
      instruction <= '0;
      pc          <= '0;
      pc_plus4    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      valid       <= 1'b1;
      instruction <= d_instruction;
      pc          <= d_pc;
      pc_plus4    <= d_pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and ROM fetch sequencer with redirect flush and fault capture
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] pm_address,
  input  logic [DATA_WIDTH-1:0] pm_instruction,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_pc_plus4,
  output logic                  running,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] fault_pc
);

  localparam logic [DATA_WIDTH:0] LAST_ADDR =
    (DATA_WIDTH+1)'(WORD_BYTES * MEMORY_DEPTH - WORD_BYTES);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH:0]   pc_next_wide;
  logic                  past_end;
  logic                  redirect_bad;
  logic                  in_run;
  logic                  capture;
  logic                  flush;

  // Range checks use one extra bit so a wrapped PC+4 still reads as out of range.
  assign pc_plus4     = pc + DATA_WIDTH'(WORD_BYTES);
  assign pc_next_wide = {1'b0, pc} + (DATA_WIDTH+1)'(WORD_BYTES);
  assign past_end     = pc_next_wide > LAST_ADDR;
  assign redirect_bad = (|redirect_pc[ADDR_LSB-1:0]) || ({1'b0, redirect_pc} > LAST_ADDR);

  assign in_run  = (state == ST_RUN);
  assign capture = in_run && !halt && !redirect_valid && !stall;
  assign flush   = !in_run || halt || redirect_valid;

  assign pm_address = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      running  <= 1'b0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
            pc      <= RESET_PC;
          end
        end
        ST_RUN: begin
          if (halt) begin
            state   <= ST_HALT;
            running <= 1'b0;
          end else if (redirect_valid) begin
            if (redirect_bad) begin
              state    <= ST_FAULT;
              running  <= 1'b0;
              fault    <= 1'b1;
              fault_pc <= redirect_pc;
            end else begin
              pc <= redirect_pc;
            end
          end else if (!stall) begin
            if (past_end) begin
              state    <= ST_FAULT;
              running  <= 1'b0;
              fault    <= 1'b1;
              fault_pc <= pc_plus4;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        ST_HALT: begin
          if (start && !halt) begin
            state   <= ST_RUN;
            running <= 1'b1;
            pc      <= RESET_PC;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  fetch_sequencer_if_id_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .en           (capture),
    .flush        (flush),
    .d_instruction(pm_instruction),
    .d_pc         (pc),
    .d_pc_plus4   (pc_plus4),
    .valid        (if_valid),
    .instruction  (if_instruction),
    .pc           (if_pc),
    .pc_plus4     (if_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pm_address;
  logic [31:0] pm_instruction;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        running;
  logic        fault;
  logic [31:0] fault_pc;

  int tests;
  int failed;

  fetch_sequencer #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(32),
    .RESET_PC    (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .halt          (halt),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pm_address    (pm_address),
    .pm_instruction(pm_instruction),
    .if_valid      (if_valid),
    .if_instruction(if_instruction),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .running       (running),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word i = 0x20080001 + i*0x00010001
  always_comb begin
    if (pm_address < 32'h80)
      pm_instruction = 32'h20080001 + {27'b0, pm_address[6:2]} * 32'h00010001;
    else
      pm_instruction = 32'hDEADBEEF;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #12;
    reset = 1'b1;
    step();
  endtask

  task automatic go_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #12;
    tests++; if (if_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", if_valid); end
    tests++; if (if_instruction !== 32'h0) begin failed++; $display("FAIL reset_instr got %h want 0", if_instruction); end
    tests++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin failed++; $display("FAIL reset_pc got %h/%h want 0/0", if_pc, if_pc_plus4); end
    tests++; if (running !== 1'b0 || fault !== 1'b0 || fault_pc !== 32'h0) begin failed++; $display("FAIL reset_status got %b %b %h want 0 0 0", running, fault, fault_pc); end
    tests++; if (pm_address !== 32'h0) begin failed++; $display("FAIL reset_pm got %h want 0", pm_address); end
    reset = 1'b1;
    step();
    tests++; if (running !== 1'b0) begin failed++; $display("FAIL idle_no_start got running=%b want 0", running); end
  endtask

  task automatic test_sequential();
    start = 1'b1;
    step();
    start = 1'b0;
    tests++; if (running !== 1'b1 || if_valid !== 1'b0 || pm_address !== 32'h0) begin failed++; $display("FAIL start_run got %b %b %h want 1 0 0", running, if_valid, pm_address); end
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== 32'h20080001) begin failed++; $display("FAIL seq0 got %b %h %h want 1 0 20080001", if_valid, if_pc, if_instruction); end
    tests++; if (if_pc_plus4 !== 32'h4 || pm_address !== 32'h4) begin failed++; $display("FAIL seq0_plus4 got %h %h want 4 4", if_pc_plus4, pm_address); end
    step();
    tests++; if (if_pc !== 32'h4 || if_instruction !== 32'h20090002) begin failed++; $display("FAIL seq1 got %h %h want 4 20090002", if_pc, if_instruction); end
    step();
    tests++; if (if_pc !== 32'h8 || if_instruction !== 32'h200A0003 || pm_address !== 32'hC) begin failed++; $display("FAIL seq2 got %h %h %h want 8 200a0003 c", if_pc, if_instruction, pm_address); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (if_pc !== 32'h8 || if_instruction !== 32'h200A0003 || pm_address !== 32'hC || if_valid !== 1'b1) begin failed++; $display("FAIL stall_hold%0d got %h %h %h %b want 8 200a0003 c 1", i, if_pc, if_instruction, pm_address, if_valid); end
    end
    stall = 1'b0;
    step();
    tests++; if (if_pc !== 32'hC || if_instruction !== 32'h200B0004) begin failed++; $display("FAIL stall_release got %h %h want c 200b0004", if_pc, if_instruction); end
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    tests++; if (if_valid !== 1'b0 || pm_address !== 32'h40) begin failed++; $display("FAIL redirect_bubble got %b %h want 0 40", if_valid, pm_address); end
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instruction !== 32'h20180011) begin failed++; $display("FAIL redirect_target got %b %h %h want 1 40 20180011", if_valid, if_pc, if_instruction); end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    step();
    tests++; if (if_valid !== 1'b0 || running !== 1'b0 || pm_address !== 32'h44) begin failed++; $display("FAIL halt got %b %b %h want 0 0 44", if_valid, running, pm_address); end
    start = 1'b1;
    step();
    tests++; if (running !== 1'b0 || pm_address !== 32'h44) begin failed++; $display("FAIL halt_start_same got %b %h want 0 44", running, pm_address); end
    halt = 1'b0;
    step();
    start = 1'b0;
    tests++; if (running !== 1'b1 || pm_address !== 32'h0) begin failed++; $display("FAIL halt_restart got %b %h want 1 0", running, pm_address); end
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== 32'h20080001) begin failed++; $display("FAIL halt_refetch got %b %h %h want 1 0 20080001", if_valid, if_pc, if_instruction); end
  endtask

  task automatic test_async_reset();
    step();
    #2;
    reset = 1'b0;
    #1;
    tests++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instruction !== 32'h0 || if_pc_plus4 !== 32'h0) begin failed++; $display("FAIL async_reset_ifid got %b %h %h %h want all 0", if_valid, if_pc, if_instruction, if_pc_plus4); end
    tests++; if (running !== 1'b0 || pm_address !== 32'h0) begin failed++; $display("FAIL async_reset_state got %b %h want 0 0", running, pm_address); end
    #2;
    reset = 1'b1;
    step();
    tests++; if (running !== 1'b0 || if_valid !== 1'b0) begin failed++; $display("FAIL post_reset_idle got %b %b want 0 0", running, if_valid); end
    go_run();
    step();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin failed++; $display("FAIL post_reset_fetch got %b %h want 1 0", if_valid, if_pc); end
  endtask

  task automatic test_fault_redirect(input logic [31:0] target);
    do_reset();
    go_run();
    step();
    redirect_valid = 1'b1; redirect_pc = target;
    step();
    redirect_valid = 1'b0;
    tests++; if (fault !== 1'b1 || fault_pc !== target || running !== 1'b0 || if_valid !== 1'b0) begin failed++; $display("FAIL fault_redirect got %b %h %b %b want 1 %h 0 0", fault, fault_pc, running, if_valid, target); end
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    tests++; if (fault !== 1'b1 || running !== 1'b0 || fault_pc !== target || if_valid !== 1'b0) begin failed++; $display("FAIL fault_sticky got %b %b %h %b want 1 0 %h 0", fault, running, fault_pc, if_valid, target); end
  endtask

  task automatic test_end_of_rom();
    do_reset();
    go_run();
    redirect_valid = 1'b1; redirect_pc = 32'h78;
    step();
    redirect_valid = 1'b0;
    step();
    tests++; if (if_pc !== 32'h78 || fault !== 1'b0) begin failed++; $display("FAIL end_0x78 got %h %b want 78 0", if_pc, fault); end
    step();
    tests++; if (if_pc !== 32'h7C || if_instruction !== 32'h20270020) begin failed++; $display("FAIL end_0x7c got %h %h want 7c 20270020", if_pc, if_instruction); end
    tests++; if (fault !== 1'b1 || fault_pc !== 32'h80) begin failed++; $display("FAIL end_fault got %b %h want 1 80", fault, fault_pc); end
    step();
    tests++; if (if_valid !== 1'b0 || if_instruction !== 32'h20270020 || running !== 1'b0) begin failed++; $display("FAIL end_hold got %b %h %b want 0 20270020 0", if_valid, if_instruction, running); end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
    test_fault_redirect(32'h42);
    test_fault_redirect(32'h80);
    test_end_of_rom();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
